// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage between the PC and decode. It keeps at most one imem request
// in flight and feeds decode through a valid/ready register backed by a one-entry skid.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_address,
    input  logic              alignment_error,
    input  logic              flush,
    output logic              stall_o,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_exc_adel
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state, state_next;
    logic              kill, kill_next;
    logic [ADDR_W-1:0] req_pc;
    logic [INST_W-1:0] skid_inst;
    logic [ADDR_W-1:0] skid_pc;
    logic              out_free, req_take, adel_load, resp_load, skid_load, skid_pop, fire;

    assign out_free  = !id_valid || id_ready;
    assign imem_addr = pc_address;
    assign fire      = (imem_req && imem_gnt) || adel_load;
    assign stall_o   = rst || (!fire && !flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
        end
    end

    // The skid is only ever occupied in HOLD, so the state doubles as its valid bit.
    always_comb begin
        state_next = state;
        kill_next  = kill;
        imem_req   = 1'b0;
        req_take   = 1'b0;
        adel_load  = 1'b0;
        resp_load  = 1'b0;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (alignment_error) begin
                    adel_load = out_free;
                end else begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        req_take   = 1'b1;
                        kill_next  = flush;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    kill_next = 1'b0;
                    if (kill || flush) begin
                        state_next = REQ;
                    end else if (out_free) begin
                        resp_load  = 1'b1;
                        state_next = REQ;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end
                end else if (flush) begin
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_next = REQ;
                end else if (id_ready) begin
                    skid_pop   = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            imem_req  = 1'b0;
            adel_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc <= '0;
        end else if (req_take) begin
            req_pc <= pc_address;
        end
    end

    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_inst <= imem_rdata;
            skid_pc   <= req_pc;
        end
    end

    // A flush only drops id_valid; the stale payload may linger but is never marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_inst     <= '0;
            id_pc       <= '0;
            id_exc_adel <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (adel_load) begin
            id_valid    <= 1'b1;
            id_inst     <= NOP_INST;
            id_pc       <= pc_address;
            id_exc_adel <= 1'b1;
        end else if (resp_load) begin
            id_valid    <= 1'b1;
            id_inst     <= imem_rdata;
            id_pc       <= req_pc;
            id_exc_adel <= 1'b0;
        end else if (skid_pop) begin
            id_valid    <= 1'b1;
            id_inst     <= skid_inst;
            id_pc       <= skid_pc;
            id_exc_adel <= 1'b0;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus random traffic for inst_fetch, checked every cycle
// against a queue-level model of what decode should see and when the PC should advance.
module tb_inst_fetch;
    localparam int                ADDR_W = 32;
    localparam int                INST_W = 32;
    localparam logic [INST_W-1:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              adel;
    } item_t;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_address;
    logic              alignment_error;
    logic              flush;
    logic              stall_o;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              id_exc_adel;

    inst_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc_address(pc_address), .alignment_error(alignment_error),
        .flush(flush), .stall_o(stall_o), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_exc_adel(id_exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: what decode is owed, in order, plus the single memory transaction in flight.
    item_t       q[$];
    bit          known, idle, inflight, alive;
    logic [31:0] inflight_pc, pc_m, reset_pc, tgt;
    int          mem_cnt;
    bit          e_req, e_bubble, e_stall;

    bit          rand_mode, rst_cmd, flush_cmd, gnt_cmd, ready_cmd, stale_cmd;
    logic [31:0] tgt_cmd;
    int          k_cmd;

    logic        s_req, s_stall, s_valid, s_adel;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        bit can_issue, mem_hit;
        @(negedge clk);
        rst = rst_cmd;
        if (rand_mode) begin
            imem_gnt = ($urandom_range(0, 9) < 7);
            id_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 24) == 0);
            tgt      = $urandom_range(0, 4095) * 4;
            if ($urandom_range(0, 7) == 0) tgt = tgt + $urandom_range(1, 3);
        end else begin
            imem_gnt = gnt_cmd;
            id_ready = ready_cmd;
            flush    = flush_cmd;
            tgt      = tgt_cmd;
        end
        pc_address      = pc_m;
        alignment_error = (pc_m[1:0] != 2'b00);
        mem_hit         = inflight && (mem_cnt == 1);
        imem_rvalid     = mem_hit || stale_cmd;
        imem_rdata      = mem_hit ? memWord(inflight_pc) : (stale_cmd ? 32'hDEAD_BEEF : $urandom());

        can_issue = known && !idle && !rst && !inflight && (q.size() < 2);
        e_req     = can_issue && !alignment_error;
        e_bubble  = can_issue && alignment_error && (q.size() == 0 || id_ready);
        e_stall   = rst || (!((e_req && imem_gnt) || e_bubble) && !flush);

        #1;
        s_req = imem_req;  s_addr = imem_addr;  s_stall = stall_o;
        s_valid = id_valid; s_pc = id_pc; s_inst = id_inst; s_adel = id_exc_adel;
        if (known) begin
            checkOutput("id_valid", id_valid, q.size() != 0);
            if (q.size() != 0) begin
                checkOutput("id_inst", id_inst, q[0].inst);
                checkOutput("id_pc", id_pc, q[0].pc);
                checkOutput("id_exc_adel", id_exc_adel, q[0].adel);
            end
            checkOutput("imem_req", imem_req, e_req);
            if (e_req) checkOutput("imem_addr", imem_addr, pc_m);
            checkOutput("stall_o", stall_o, e_stall);
        end
    endtask

    task automatic updateModel();
        item_t it;
        bit    hs, resp;
        if (rst) begin
            q.delete();
            inflight = 0;
            alive    = 0;
            idle     = 1;
            known    = 1;
            pc_m     = reset_pc;
            return;
        end
        if (!known) return;
        hs   = e_req && imem_gnt;
        resp = inflight && (mem_cnt == 1);
        if (q.size() != 0 && id_ready) void'(q.pop_front());
        if (flush) begin
            q.delete();
            alive = 0;
        end
        if (resp) begin
            if (alive) begin
                it.inst = memWord(inflight_pc); it.pc = inflight_pc; it.adel = 1'b0;
                q.push_back(it);
            end
            inflight = 0;
        end else if (inflight) begin
            mem_cnt--;
        end
        if (hs) begin
            inflight    = 1;
            alive       = !flush;
            inflight_pc = pc_m;
            mem_cnt     = (k_cmd == 0) ? int'($urandom_range(1, 3)) : k_cmd;
        end
        if (e_bubble && !flush) begin
            it.inst = NOP; it.pc = pc_m; it.adel = 1'b1;
            q.push_back(it);
        end
        if (flush) pc_m = tgt;
        else if (!e_stall) pc_m = pc_m + 32'd4;
        idle = 0;
    endtask

    task automatic runCycle();
        applyStimulus();
        @(posedge clk);
        updateModel();
    endtask

    task automatic doReset(input logic [31:0] pc);
        reset_pc = pc;
        rst_cmd  = 1;
        repeat (3) runCycle();
        rst_cmd  = 0;
    endtask

    initial begin
        rst = 1; pc_address = '0; alignment_error = 0; flush = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = '0; id_ready = 0;
        known = 0; idle = 0; inflight = 0; alive = 0; inflight_pc = '0; pc_m = '0;
        reset_pc = '0; tgt = '0; mem_cnt = 0;
        rand_mode = 0; rst_cmd = 0; flush_cmd = 0; gnt_cmd = 1; ready_cmd = 1; stale_cmd = 0;
        tgt_cmd = '0; k_cmd = 1;

        $display("[TB] scenario 1: basic fetch, k=1");
        doReset(32'h0);
        for (int c = 1; c <= 8; c++) begin
            runCycle();
            if (c == 1) checkOutput("t1_idle_req", s_req, 0);
            if (c == 2) begin
                checkOutput("t1_first_req", s_req, 1);
                checkOutput("t1_first_addr", s_addr, 32'h0);
            end
            if (c == 4 || c == 6 || c == 8) begin
                checkOutput("t1_valid", s_valid, 1);
                checkOutput("t1_pc", s_pc, (c - 4) * 2);
            end
            if (c == 5 || c == 7) checkOutput("t1_gap", s_valid, 0);
        end

        $display("[TB] scenario 2: decode backpressure");
        ready_cmd = 0;
        doReset(32'h10);
        for (int c = 1; c <= 9; c++) begin
            if (c == 8) ready_cmd = 1;
            runCycle();
            if (c == 6 || c == 7) begin
                checkOutput("t2_hold_req", s_req, 0);
                checkOutput("t2_hold_stall", s_stall, 1);
                checkOutput("t2_hold_pc", s_pc, 32'h10);
            end
            if (c == 8) begin
                checkOutput("t2_rel_first", s_pc, 32'h10);
                checkOutput("t2_rel_first_req", s_req, 0);
            end
            if (c == 9) begin
                checkOutput("t2_rel_second_v", s_valid, 1);
                checkOutput("t2_rel_second", s_pc, 32'h14);
                checkOutput("t2_rel_second_inst", s_inst, memWord(32'h14));
            end
        end

        $display("[TB] scenario 3: flush during WAIT");
        k_cmd = 3;
        doReset(32'h20);
        for (int c = 1; c <= 10; c++) begin
            flush_cmd = (c == 3);
            tgt_cmd   = 32'h100;
            runCycle();
            if (c >= 4) checkOutput("t3_no_stale", s_valid && (s_pc == 32'h20), 0);
            if (c == 6) begin
                checkOutput("t3_req", s_req, 1);
                checkOutput("t3_addr", s_addr, 32'h100);
            end
            if (c == 10) checkOutput("t3_target_pc", s_pc, 32'h100);
        end
        flush_cmd = 0;

        $display("[TB] scenario 4a: flush with grant");
        k_cmd = 1;
        doReset(32'h40);
        for (int c = 1; c <= 6; c++) begin
            flush_cmd = (c == 2);
            tgt_cmd   = 32'h200;
            runCycle();
            if (c == 3) checkOutput("t4a_after_flush", s_valid, 0);
            if (c == 4) checkOutput("t4a_addr", s_addr, 32'h200);
            if (c == 6) checkOutput("t4a_pc", s_pc, 32'h200);
        end

        $display("[TB] scenario 4b: flush with rvalid");
        k_cmd = 2;
        doReset(32'h40);
        for (int c = 1; c <= 8; c++) begin
            flush_cmd = (c == 4);
            tgt_cmd   = 32'h300;
            runCycle();
            if (c == 5) begin
                checkOutput("t4b_after_flush", s_valid, 0);
                checkOutput("t4b_addr", s_addr, 32'h300);
            end
            if (c == 8) checkOutput("t4b_pc", s_pc, 32'h300);
        end
        flush_cmd = 0;

        $display("[TB] scenario 5: misaligned PC");
        k_cmd = 1;
        doReset(32'h102);
        for (int c = 1; c <= 3; c++) begin
            runCycle();
            if (c == 2) begin
                checkOutput("t5_req", s_req, 0);
                checkOutput("t5_stall", s_stall, 0);
            end
            if (c == 3) begin
                checkOutput("t5_valid", s_valid, 1);
                checkOutput("t5_adel", s_adel, 1);
                checkOutput("t5_inst", s_inst, NOP);
                checkOutput("t5_pc", s_pc, 32'h102);
            end
        end

        $display("[TB] scenario 6: reset during WAIT with stale response");
        k_cmd = 1;
        ready_cmd = 0;
        doReset(32'h80);
        for (int c = 1; c <= 10; c++) begin
            rst_cmd   = (c == 6 || c == 7);
            stale_cmd = (c == 7 || c == 8);
            runCycle();
            if (c == 3) k_cmd = 3;
            if (c == 4) checkOutput("t6_pre_pc", s_pc, 32'h80);
            if (c == 7 || c == 8) begin
                checkOutput("t6_valid", s_valid, 0);
                checkOutput("t6_inst", s_inst, 0);
                checkOutput("t6_pc", s_pc, 0);
                checkOutput("t6_adel", s_adel, 0);
                checkOutput("t6_req", s_req, 0);
                checkOutput("t6_stall", s_stall, 1);
            end
            if (c == 9) checkOutput("t6_restart_addr", s_addr, 32'h80);
            if (c == 10) checkOutput("t6_no_stale", s_valid, 0);
        end
        rst_cmd = 0;
        stale_cmd = 0;

        $display("[TB] random traffic");
        k_cmd = 0;
        doReset(32'h1000);
        rand_mode = 1;
        repeat (3000) runCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
